// File: rtl/mbz_pkg.sv
// rtl/mbz_pkg.sv - shared types and constants for the NXM memory-cycle controller
package mbz_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    SEQ  = 3'd2,
    CLR  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [1:0] DIAG_STAT = 2'd0;
  localparam logic [1:0] DIAG_ERR  = 2'd1;
  localparam logic [1:0] DIAG_ERA  = 2'd2;
  localparam logic [1:0] DIAG_CNT  = 2'd3;

  localparam logic [7:0] TMO_LIMIT_DFLT = 8'hFF;

endpackage

// File: rtl/mbz_nxm_ctl_if.sv
// rtl/mbz_nxm_ctl_if.sv - memory-cycle bus between requester/memory side and NXM controller
interface mbz_nxm_ctl_if #(
  parameter int RW    = 2,
  parameter int ADR_W = 22
);
  logic             MEM_START;
  logic             MEM_RD_RQ;
  logic [RW-1:0]    REQ_ID;
  logic [ADR_W-1:0] MEM_ADR;
  logic             ACKN;
  logic             NXM_ACK;
  logic             NXM_DATA_VAL;

  modport master (
    output MEM_START, MEM_RD_RQ, REQ_ID, MEM_ADR, ACKN,
    input  NXM_ACK, NXM_DATA_VAL
  );

  modport slave (
    input  MEM_START, MEM_RD_RQ, REQ_ID, MEM_ADR, ACKN,
    output NXM_ACK, NXM_DATA_VAL
  );
endinterface

// File: rtl/mbz_nxm_timer.sv
// rtl/mbz_nxm_timer.sv - TICK edge detect, saturating timeout counter and limit compare
module mbz_nxm_timer #(
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clr,
  input  logic             en,
  input  logic [TMO_W-1:0] limit,
  output logic             tmo_hit,
  output logic [TMO_W-1:0] count
);

  logic             tick_d_q, tick_d_d;
  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             tick_p;

  always_comb begin
    tick_d_d = tick;
    tick_p   = tick & ~tick_d_q;
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    cnt_d    = cnt_q;
    tmo_hit  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en && tick_p) begin
      cnt_d   = cnt_inc;
      // compare against the post-increment value so limit N fires on the Nth edge
      tmo_hit = (cnt_inc == limit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_d_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      tick_d_q <= tick_d_d;
      cnt_q    <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/mbz_nxm_ctl.sv
// rtl/mbz_nxm_ctl.sv - memory-cycle timeout, synthetic NXM completion and error address capture
module mbz_nxm_ctl
  import mbz_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TMO_W   = 8,
  parameter int NXM_SEQ = 5,
  parameter int ADR_W   = 22,
  localparam int RW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              RESET_n,
  mbz_nxm_ctl_if.slave      bus,
  input  logic              TICK,
  input  logic [TMO_W-1:0]  TMO_LIMIT,
  input  logic [NREQ-1:0]   ERR_CLR,
  input  logic              ANY_EBOX_ERR,
  output logic              CORE_BUSY_NXM,
  output logic              NXM_ANY,
  output logic [NREQ-1:0]   NXM_ERR,
  output logic              HOLD_ERA,
  output logic [ADR_W-1:0]  ERA_ADR,
  output logic [RW-1:0]     ERA_ID,
  output logic              ERA_WR,
  input  logic [1:0]        DIAG_SEL,
  output logic [7:0]        DIAG_Q
);

  state_e               state_q, state_d;
  logic                 start_d_q, start_d_d;
  logic                 hold_rd_q, hold_rd_d;
  logic [RW-1:0]        hold_id_q, hold_id_d;
  logic [TMO_W-1:0]     lim_q, lim_d;
  logic [NXM_SEQ-1:0]   seq_q, seq_d;
  logic                 nxm_flg_q, nxm_flg_d;
  logic [NREQ-1:0]      nxm_err_q, nxm_err_d;
  logic [ADR_W-1:0]     era_adr_q, era_adr_d;
  logic [RW-1:0]        era_id_q, era_id_d;
  logic                 era_wr_q, era_wr_d;
  logic                 start_rise, tmr_clr, tmo_hit;
  logic [TMO_W-1:0]     count;

  mbz_nxm_timer #(.TMO_W(TMO_W)) u_timer (
    .clk     (clk),
    .rst_n   (RESET_n),
    .tick    (TICK),
    .clr     (tmr_clr),
    .en      (state_q == WAIT),
    .limit   (lim_q),
    .tmo_hit (tmo_hit),
    .count   (count)
  );

  assign HOLD_ERA = (|nxm_err_q) | nxm_flg_q | ANY_EBOX_ERR;

  always_comb begin
    state_d    = state_q;
    start_d_d  = bus.MEM_START;
    start_rise = bus.MEM_START & ~start_d_q;
    hold_rd_d  = hold_rd_q;
    hold_id_d  = hold_id_q;
    lim_d      = lim_q;
    seq_d      = seq_q;
    nxm_flg_d  = nxm_flg_q;
    nxm_err_d  = nxm_err_q & ~ERR_CLR;
    era_adr_d  = era_adr_q;
    era_id_d   = era_id_q;
    era_wr_d   = era_wr_q;
    tmr_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          hold_rd_d = bus.MEM_RD_RQ;
          hold_id_d = bus.REQ_ID;
          lim_d     = (TMO_LIMIT == '0) ? '1 : TMO_LIMIT;
          tmr_clr   = 1'b1;
          state_d   = WAIT;
          if (!HOLD_ERA) begin
            era_adr_d = bus.MEM_ADR;
            era_id_d  = bus.REQ_ID;
            era_wr_d  = ~bus.MEM_RD_RQ;
          end
        end
      end
      WAIT: begin
        // a real acknowledge beats a timeout landing on the same clock
        if (bus.ACKN) begin
          state_d = DONE;
        end else if (!bus.MEM_START) begin
          state_d = IDLE;
        end else if (tmo_hit) begin
          nxm_flg_d = 1'b1;
          seq_d     = {{(NXM_SEQ-1){1'b0}}, 1'b1};
          state_d   = SEQ;
        end
      end
      SEQ: begin
        seq_d = seq_q << 1;
        if (seq_q[NXM_SEQ-1]) state_d = CLR;
      end
      CLR: begin
        if (!bus.MEM_START) begin
          nxm_flg_d            = 1'b0;
          nxm_err_d[hold_id_q] = 1'b1;
          state_d              = IDLE;
        end
      end
      DONE: begin
        if (!bus.MEM_START) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= IDLE;
      start_d_q <= 1'b0;
      hold_rd_q <= 1'b0;
      hold_id_q <= '0;
      lim_q     <= '0;
      seq_q     <= '0;
      nxm_flg_q <= 1'b0;
      nxm_err_q <= '0;
      era_adr_q <= '0;
      era_id_q  <= '0;
      era_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_d_q <= start_d_d;
      hold_rd_q <= hold_rd_d;
      hold_id_q <= hold_id_d;
      lim_q     <= lim_d;
      seq_q     <= seq_d;
      nxm_flg_q <= nxm_flg_d;
      nxm_err_q <= nxm_err_d;
      era_adr_q <= era_adr_d;
      era_id_q  <= era_id_d;
      era_wr_q  <= era_wr_d;
    end
  end

  // seq_q bit k is timing pulse T(2+k)
  assign CORE_BUSY_NXM    = |seq_q[NXM_SEQ-2:0];
  assign bus.NXM_ACK      = seq_q[NXM_SEQ-2];
  assign bus.NXM_DATA_VAL = seq_q[NXM_SEQ-1] & hold_rd_q;
  assign NXM_ANY          = nxm_flg_q;
  assign NXM_ERR          = nxm_err_q;
  assign ERA_ADR          = era_adr_q;
  assign ERA_ID           = era_id_q;
  assign ERA_WR           = era_wr_q;

  always_comb begin
    DIAG_Q = '0;
    case (DIAG_SEL)
      DIAG_STAT: DIAG_Q = {nxm_flg_q, state_q[1:0], |seq_q, count[TMO_W-1 -: 4]};
      DIAG_ERR:  DIAG_Q = 8'(nxm_err_q);
      DIAG_ERA:  DIAG_Q = {HOLD_ERA, era_wr_q, 6'(era_id_q)};
      DIAG_CNT:  DIAG_Q = 8'(count);
      default:   DIAG_Q = '0;
    endcase
  end

endmodule

// File: tb/tb_mbz_nxm_ctl.sv
// tb/tb_mbz_nxm_ctl.sv - scoreboard bench for the NXM memory-cycle controller
module tb_mbz_nxm_ctl;
  import mbz_pkg::*;

  localparam int NREQ    = 4;
  localparam int TMO_W   = 8;
  localparam int NXM_SEQ = 5;
  localparam int ADR_W   = 22;
  localparam int RW      = 2;

  logic              clk = 1'b0;
  logic              RESET_n;
  logic              TICK;
  logic [TMO_W-1:0]  TMO_LIMIT;
  logic [NREQ-1:0]   ERR_CLR;
  logic              ANY_EBOX_ERR;
  logic              CORE_BUSY_NXM;
  logic              NXM_ANY;
  logic [NREQ-1:0]   NXM_ERR;
  logic              HOLD_ERA;
  logic [ADR_W-1:0]  ERA_ADR;
  logic [RW-1:0]     ERA_ID;
  logic              ERA_WR;
  logic [1:0]        DIAG_SEL;
  logic [7:0]        DIAG_Q;

  mbz_nxm_ctl_if #(.RW(RW), .ADR_W(ADR_W)) bus ();

  mbz_nxm_ctl #(.NREQ(NREQ), .TMO_W(TMO_W), .NXM_SEQ(NXM_SEQ), .ADR_W(ADR_W)) dut (
    .clk           (clk),
    .RESET_n       (RESET_n),
    .bus           (bus),
    .TICK          (TICK),
    .TMO_LIMIT     (TMO_LIMIT),
    .ERR_CLR       (ERR_CLR),
    .ANY_EBOX_ERR  (ANY_EBOX_ERR),
    .CORE_BUSY_NXM (CORE_BUSY_NXM),
    .NXM_ANY       (NXM_ANY),
    .NXM_ERR       (NXM_ERR),
    .HOLD_ERA      (HOLD_ERA),
    .ERA_ADR       (ERA_ADR),
    .ERA_ID        (ERA_ID),
    .ERA_WR        (ERA_WR),
    .DIAG_SEL      (DIAG_SEL),
    .DIAG_Q        (DIAG_Q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: one entry per expected NXM completion, value = cycle was a read
  bit exp_q[$];
  bit cur_rd = 1'b0;
  int exp_dv_cnt = 0;
  int dv_cnt = 0;
  int cyc = 0;
  logic any_prev = 1'b0;

  always @(negedge clk) begin
    if (NXM_ANY && !any_prev) cyc = 0;
    else cyc = cyc + 1;
    any_prev = NXM_ANY;
    if (bus.NXM_ACK) begin
      chk("ack_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        cur_rd = exp_q.pop_front();
        chk("ack_ofs", cyc, NXM_SEQ - 2);
        chk("busy_at_ack", CORE_BUSY_NXM, 1);
      end
    end
    if (bus.NXM_DATA_VAL) begin
      dv_cnt++;
      chk("dv_ofs", cyc, NXM_SEQ - 1);
      chk("dv_is_read", cur_rd, 1);
      chk("busy_at_dv", CORE_BUSY_NXM, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick_pulse();
    TICK = 1'b1;
    step();
    TICK = 1'b0;
    step();
  endtask

  task automatic start_cyc(input bit rd, input logic [RW-1:0] id, input logic [ADR_W-1:0] adr,
                           input logic [TMO_W-1:0] lim, input bit exp_nxm);
    bus.MEM_RD_RQ = rd;
    bus.REQ_ID    = id;
    bus.MEM_ADR   = adr;
    TMO_LIMIT     = lim;
    bus.MEM_START = 1'b1;
    if (exp_nxm) begin
      exp_q.push_back(rd);
      if (rd) exp_dv_cnt++;
    end
    step();
  endtask

  task automatic end_cyc();
    bus.MEM_START = 1'b0;
    step();
  endtask

  task automatic ack_pulse();
    bus.ACKN = 1'b1;
    step();
    bus.ACKN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESET_n = 1'b0;
    TICK = 1'b0; TMO_LIMIT = '0; ERR_CLR = '0; ANY_EBOX_ERR = 1'b0; DIAG_SEL = DIAG_STAT;
    bus.MEM_START = 1'b0; bus.MEM_RD_RQ = 1'b0; bus.REQ_ID = '0; bus.MEM_ADR = '0; bus.ACKN = 1'b0;
    #12;
    chk("rst_any", NXM_ANY, 0);
    chk("rst_err", NXM_ERR, 0);
    chk("rst_hold", HOLD_ERA, 0);
    chk("rst_era", ERA_ADR, 0);
    chk("rst_diag", DIAG_Q, 0);
    step();
    RESET_n = 1'b1;
    steps(2);

    // acknowledged read
    start_cyc(1'b1, 2'd0, 22'h012345, 8'd10, 1'b0);
    repeat (3) tick_pulse();
    ack_pulse();
    step();
    chk("t1_any", NXM_ANY, 0);
    end_cyc();
    step();
    chk("t1_err", NXM_ERR, 0);
    chk("t1_era", ERA_ADR, 22'h012345);
    chk("t1_diag_idle", DIAG_Q, 8'h00);

    // write timeout
    start_cyc(1'b0, 2'd3, 22'h00ABCD, 8'd2, 1'b1);
    repeat (2) tick_pulse();
    chk("t3_any", NXM_ANY, 1);
    steps(8);
    end_cyc();
    chk("t3_err", NXM_ERR, 4'b1000);
    chk("t3_era_wr", ERA_WR, 1);
    chk("t3_era_adr", ERA_ADR, 22'h00ABCD);
    ERR_CLR = 4'b1000;
    step();
    ERR_CLR = '0;
    chk("t3_cleared", NXM_ERR, 0);

    // read timeout at limit 4
    start_cyc(1'b1, 2'd2, 22'h3F0000, 8'd4, 1'b1);
    repeat (3) tick_pulse();
    chk("t2_any_pre", NXM_ANY, 0);
    tick_pulse();
    chk("t2_any", NXM_ANY, 1);
    steps(8);
    end_cyc();
    chk("t2_err", NXM_ERR, 4'b0100);
    chk("t2_era_adr", ERA_ADR, 22'h3F0000);
    chk("t2_era_id", ERA_ID, 2);
    chk("t2_era_wr", ERA_WR, 0);

    // ERA frozen while a flag is set
    start_cyc(1'b1, 2'd0, 22'h000100, 8'd10, 1'b0);
    ack_pulse();
    end_cyc();
    chk("t4_era_frozen", ERA_ADR, 22'h3F0000);
    chk("t4_hold", HOLD_ERA, 1);
    ERR_CLR = 4'b0100;
    step();
    ERR_CLR = '0;
    chk("t4_hold_clr", HOLD_ERA, 0);
    start_cyc(1'b0, 2'd1, 22'h000100, 8'd10, 1'b0);
    ack_pulse();
    end_cyc();
    chk("t4_era_load", ERA_ADR, 22'h000100);
    chk("t4_era_id", ERA_ID, 1);
    ANY_EBOX_ERR = 1'b1;
    #1;
    chk("ebox_hold", HOLD_ERA, 1);
    ANY_EBOX_ERR = 1'b0;
    step();

    // ACKN coincident with the limit tick
    start_cyc(1'b1, 2'd3, 22'h001234, 8'd3, 1'b0);
    repeat (2) tick_pulse();
    TICK = 1'b1; bus.ACKN = 1'b1;
    step();
    TICK = 1'b0; bus.ACKN = 1'b0;
    step();
    chk("t5_no_nxm", NXM_ANY, 0);
    chk("t5_diag_done", DIAG_Q[6:5], 2'(DONE));
    end_cyc();
    chk("t5_err", NXM_ERR, 0);

    // set and clear of the same flag on one clock
    start_cyc(1'b1, 2'd1, 22'h002000, 8'd1, 1'b1);
    tick_pulse();
    steps(8);
    bus.MEM_START = 1'b0;
    ERR_CLR = 4'b0010;
    step();
    ERR_CLR = '0;
    step();
    chk("t5_set_wins", NXM_ERR, 4'b0010);

    // reset in the middle of the completion sequence
    start_cyc(1'b1, 2'd1, 22'h003000, 8'd2, 1'b0);
    repeat (2) tick_pulse();
    chk("t6_busy_t3", CORE_BUSY_NXM, 1);
    RESET_n = 1'b0;
    #1;
    chk("t6_rst_any", NXM_ANY, 0);
    chk("t6_rst_busy", CORE_BUSY_NXM, 0);
    chk("t6_rst_ack", bus.NXM_ACK, 0);
    chk("t6_rst_err", NXM_ERR, 0);
    chk("t6_rst_diag", DIAG_Q, 0);
    bus.MEM_START = 1'b0;
    step();
    RESET_n = 1'b1;
    steps(2);

    // limit 0 behaves as all-ones
    start_cyc(1'b1, 2'd0, 22'h004000, 8'd0, 1'b1);
    repeat (254) tick_pulse();
    chk("t6_any_254", NXM_ANY, 0);
    DIAG_SEL = DIAG_CNT;
    #1;
    chk("t6_cnt_254", DIAG_Q, 254);
    DIAG_SEL = DIAG_STAT;
    tick_pulse();
    chk("t6_any_255", NXM_ANY, 1);
    chk("t6_lim_dflt", {24'd0, TMO_LIMIT_DFLT}, 255);
    steps(8);
    end_cyc();
    chk("t6_err", NXM_ERR, 4'b0001);

    steps(4);
    chk("sb_empty", exp_q.size(), 0);
    chk("dv_count", dv_cnt, exp_dv_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
